// File: rtl/logic_sched.sv
// logic_sched: round-robin scheduler sharing one accumulate/xor datapath
// between PAR_REQ_NUM requesters, one fixed-length burst per grant.
// Sequence per grant: IDLE -> CLEAR (datapath clear) -> STREAM (burst words,
// idle cycles masked to zero) -> DRAIN (datapath latency) -> RESP (hold result).
// Optional build macro: LOGIC_SCHED_TIMEOUT_EN adds a stall counter that
// aborts a stalled burst and returns its partial result with ob_rsp_err=1.
module logic_sched #(
    parameter int PAR_DATA_BITS = 8,
    parameter int PAR_REQ_NUM   = 4,
    parameter int PAR_BURST_LEN = 4,
    parameter int PAR_DP_LAT    = 1,
    parameter int PAR_TIMEOUT   = 16,
    localparam int ID_W = (PAR_REQ_NUM > 1) ? $clog2(PAR_REQ_NUM) : 1
) (
    input  logic                                 ib_clk,
    input  logic                                 ib_rst,
    input  logic [PAR_REQ_NUM-1:0]               ivG_req_valid,
    input  logic [PAR_REQ_NUM*PAR_DATA_BITS-1:0] ivG_req_data,
    output logic [PAR_REQ_NUM-1:0]               ovG_req_ready,
    output logic                                 ob_dp_rst,
    output logic [PAR_DATA_BITS-1:0]             ovG_dp_data,
    input  logic [PAR_DATA_BITS-1:0]             ivG_dp_data,
    output logic                                 ob_rsp_valid,
    input  logic                                 ib_rsp_ready,
    output logic [ID_W-1:0]                      ovG_rsp_id,
    output logic [PAR_DATA_BITS-1:0]             ovG_rsp_data,
    output logic                                 ob_rsp_err
);

    localparam int WC_W = $clog2(PAR_BURST_LEN + 1);
    localparam int LC_W = $clog2(PAR_DP_LAT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [ID_W-1:0]          grant_q, grant_d;
    logic [ID_W-1:0]          last_q, last_d;
    logic [WC_W-1:0]          wcnt_q, wcnt_d;
    logic [LC_W-1:0]          lcnt_q, lcnt_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
    logic [PAR_DATA_BITS-1:0] rsp_data_q, rsp_data_d;

    logic                     pick_found;
    logic [ID_W-1:0]          pick_id;
    logic [ID_W-1:0]          scan_idx;
    logic                     in_stream;
    logic                     gvalid;
    logic [PAR_DATA_BITS-1:0] gdata;
    logic                     accept;

`ifdef LOGIC_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(PAR_TIMEOUT + 1);
    logic [TO_W-1:0] stall_q, stall_d;
    logic            abort_q, abort_d;
    logic            rsp_err_q, rsp_err_d;
`endif

    // Round-robin pick: first valid requester after the last served one.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int k = 1; k <= PAR_REQ_NUM; k++) begin
            scan_idx = ID_W'((int'(last_q) + k) % PAR_REQ_NUM);
            if (!pick_found && ivG_req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    // Datapath and requester handshake; the datapath adds every cycle so
    // anything other than an accepted word must be driven as zero.
    always_comb begin
        in_stream     = (state_q == S_STREAM);
        gvalid        = ivG_req_valid[grant_q];
        gdata         = ivG_req_data[int'(grant_q)*PAR_DATA_BITS +: PAR_DATA_BITS];
        accept        = in_stream && gvalid;
        ovG_dp_data   = accept ? gdata : '0;
        ovG_req_ready = '0;
        if (in_stream) ovG_req_ready[grant_q] = 1'b1;
        ob_dp_rst     = ib_rst || (state_q == S_CLEAR);
    end

    // Controller next-state: grant, clear, stream, drain latency, hold response.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        lcnt_d      = lcnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef LOGIC_SCHED_TIMEOUT_EN
        stall_d     = stall_q;
        abort_d     = abort_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_id;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                wcnt_d  = '0;
                state_d = S_STREAM;
`ifdef LOGIC_SCHED_TIMEOUT_EN
                stall_d = '0;
                abort_d = 1'b0;
`endif
            end
            S_STREAM: begin
                if (accept) begin
`ifdef LOGIC_SCHED_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (wcnt_q == WC_W'(PAR_BURST_LEN - 1)) begin
                        wcnt_d  = '0;
                        lcnt_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
`ifdef LOGIC_SCHED_TIMEOUT_EN
                else if (stall_q == TO_W'(PAR_TIMEOUT - 1)) begin
                    // Stalled too long: drain what has been accumulated so far.
                    stall_d = '0;
                    abort_d = 1'b1;
                    lcnt_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            S_DRAIN: begin
                if (lcnt_q == LC_W'(PAR_DP_LAT - 1)) begin
                    lcnt_d      = '0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = grant_q;
                    rsp_data_d  = ivG_dp_data;
`ifdef LOGIC_SCHED_TIMEOUT_EN
                    rsp_err_d   = abort_q;
`endif
                    state_d     = S_RESP;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (ib_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_d      = grant_q;
`ifdef LOGIC_SCHED_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any burst in flight and restarts at requester 0.
    always_ff @(posedge ib_clk) begin
        if (ib_rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            last_q      <= ID_W'(PAR_REQ_NUM - 1);
            wcnt_q      <= '0;
            lcnt_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifdef LOGIC_SCHED_TIMEOUT_EN
            stall_q     <= '0;
            abort_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            lcnt_q      <= lcnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef LOGIC_SCHED_TIMEOUT_EN
            stall_q     <= stall_d;
            abort_q     <= abort_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign ob_rsp_valid = rsp_valid_q;
    assign ovG_rsp_id   = rsp_id_q;
    assign ovG_rsp_data = rsp_data_q;
`ifdef LOGIC_SCHED_TIMEOUT_EN
    assign ob_rsp_err   = rsp_err_q;
`else
    assign ob_rsp_err   = 1'b0;
`endif

endmodule

// File: doc/logic_sched.md
Name: logic_sched

Overview:
- Round-robin scheduler that shares one accumulate/xor datapath instance (PAR_DATA_BITS wide, synchronous clear, per-cycle accumulate) between PAR_REQ_NUM requesters.
- Grants one fixed-length burst at a time.
- Clears the datapath before each burst and zero-masks idle cycles.
- After the datapath latency, captures the datapath result and returns it to the requester with that requester's id.

Parameters:
- PAR_DATA_BITS, 8: data width of the requester words and the datapath.
- PAR_REQ_NUM, 4: number of requesters, >=2.
- PAR_BURST_LEN, 4: words accepted per grant, >=1.
- PAR_DP_LAT, 1: cycles from the last word on ovG_dp_data to a valid ivG_dp_data, >=1.
- PAR_TIMEOUT, 16: stall limit in cycles; used only with LOGIC_SCHED_TIMEOUT_EN.

Ports:
- ib_clk  in  1  clock; all logic on posedge.
- ib_rst  in  1  reset, synchronous, active-high.
- ivG_req_valid  in  PAR_REQ_NUM  per-requester word valid.
- ivG_req_data  in  PAR_REQ_NUM*PAR_DATA_BITS  flattened words; requester i at bits [i*W +: W].
- ovG_req_ready  out  PAR_REQ_NUM  per-requester word accept, one-hot or zero.
- ob_dp_rst  out  1  synchronous clear to the datapath.
- ovG_dp_data  out  PAR_DATA_BITS  word to the datapath.
- ivG_dp_data  in  PAR_DATA_BITS  datapath result.
- ob_rsp_valid  out  1  response valid.
- ib_rsp_ready  in  1  response accept.
- ovG_rsp_id  out  max(1,clog2(PAR_REQ_NUM))  granted requester index.
- ovG_rsp_data  out  PAR_DATA_BITS  captured result.
- ob_rsp_err  out  1  burst aborted by timeout; tied 0 without the macro.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; word and latency counters = 0.
  - last_grant = PAR_REQ_NUM-1, so requester 0 has first priority.
  - ob_rsp_valid, ovG_rsp_id, ovG_rsp_data, ob_rsp_err = 0; ovG_req_ready = 0.
  - ob_dp_rst = 1 during reset.
- Outputs:
  - ob_dp_rst = ib_rst | (state==CLEAR).
  - ovG_dp_data = granted word when state==STREAM and that requester's valid is 1; otherwise 0. The datapath adds every cycle, so masking is mandatory.
  - ovG_req_ready[g] = 1 only in STREAM, for g = the granted id. Combinational.
- IDLE:
  - If any valid is set, grant the first requester with valid set, scanning last_grant+1, +2, … modulo PAR_REQ_NUM.
  - Latch the grant id and go to CLEAR.
  - No valid set: stay in IDLE.
- CLEAR: one cycle with ob_dp_rst=1 -> STREAM.
- STREAM:
  - A word is accepted when valid&ready.
  - Word count increments per accepted word.
  - After the PAR_BURST_LEN-th accept -> DRAIN.
  - A low valid inserts a zero bubble; the burst is not aborted (unless timeout is enabled).
  - Valids of non-granted requesters are ignored.
- DRAIN:
  - Lasts PAR_DP_LAT cycles with ovG_dp_data=0.
  - At the end of the last DRAIN cycle, register ivG_dp_data into ovG_rsp_data and ovG_rsp_id; set ob_rsp_valid=1 -> RESP.
- RESP:
  - Response outputs are held stable while ib_rsp_ready=0; no new grant is made.
  - On valid&ready: ob_rsp_valid=0, last_grant=id, go to IDLE.
  - The earliest next grant is the following cycle (one IDLE cycle minimum).
- Arithmetic: sums wrap modulo 2^PAR_DATA_BITS; the controller only masks and does no arithmetic.
- Reset during STREAM/DRAIN/RESP:
  - Burst discarded, no response emitted, ready drops the next cycle.
  - Arbitration restarts at requester 0.

Optional Feature:
- Macro: LOGIC_SCHED_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive STREAM cycles without an accept and clears on each accept.
  - When it reaches PAR_TIMEOUT, go to DRAIN; the response carries the partial result with ob_rsp_err=1.
  - ob_rsp_err clears on response handshake.
- Undefined:
  - No counter; bursts wait indefinitely; ob_rsp_err is constant 0.

Test Plan:
Bench datapath model: registered wrap-around accumulator, PAR_DP_LAT=1. Configuration: PAR_REQ_NUM=4, PAR_DATA_BITS=8, PAR_BURST_LEN=4.
1. After reset, req1 sends 1,2,3,4 back-to-back -> one ob_dp_rst pulse before the first word; ovG_rsp_id=1, ovG_rsp_data=0x0A; ob_rsp_valid is asserted 2 cycles after the last accept.
2. req2 sends 0xFF,0x02,0x00,0x00 -> ovG_rsp_data=0x01 (wrap).
3. All four valids held high, rsp_ready=1 -> grant order 0,1,2,3,0; each grant is preceded by exactly one CLEAR cycle.
4. req0 sends 1,2, valid low 3 cycles, then 3,4 -> ovG_dp_data=0 during the bubble; result 0x0A.
5. ib_rsp_ready low 5 cycles after a burst -> ob_rsp_valid, id and data stable; ovG_req_ready=0 throughout; next grant only after the handshake.
6. Reset asserted after 2 accepted words of req3 -> no response; the next grant goes to req0. With LOGIC_SCHED_TIMEOUT_EN and PAR_TIMEOUT=8, req0 sends 1,2 then stalls -> after 8 cycles a response with data=0x03, ob_rsp_err=1.
